// File: rtl/i2c_slave_regfile.sv
// I2C target backed by a 256-byte register file, with a registered host port
// for on-chip access. Bus inputs are oversampled by clk (at least 16x SCL).
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] host_addr,
    input  logic       host_we,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       host_wr_drop,
    output logic       busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [3:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic       ack_drv;
    logic       rd_ack;
    logic       rw;
    logic [7:0] wr_byte;
    logic [7:0] rd_byte;
    logic       i2c_wr;

    logic [7:0] mem [256];

    // Synchroniser chain plus one history flop; idle bus level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign wr_byte = {shift[6:0], sda_s};
    assign rd_byte = mem[ptr];
    assign i2c_wr  = !rst && (state == S_WDATA) && scl_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            ptr       <= 8'd0;
            bit_cnt   <= 3'd0;
            ack_drv   <= 1'b0;
            rd_ack    <= 1'b0;
            rw        <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 8'd0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift   <= wr_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (wr_byte[7:1] == DEV_ADDR) begin
                                    state   <= S_ADDR_ACK;
                                    busy    <= 1'b1;
                                    rw      <= wr_byte[0];
                                    ack_drv <= 1'b0;
                                end else begin
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    // First fall drives the ACK, second fall ends it and, for
                    // reads, presents the MSB of the first data byte.
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                sda_oe  <= 1'b1;
                                ack_drv <= 1'b1;
                            end else begin
                                ack_drv <= 1'b0;
                                bit_cnt <= 3'd0;
                                if (rw) begin
                                    shift  <= rd_byte;
                                    sda_oe <= ~rd_byte[7];
                                    state  <= S_RDATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= S_PTR;
                                end
                            end
                        end
                    end
                    S_PTR: begin
                        if (scl_rise) begin
                            shift   <= wr_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr     <= wr_byte;
                                ack_drv <= 1'b0;
                                state   <= S_PTR_ACK;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                sda_oe  <= 1'b1;
                                ack_drv <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                ack_drv <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (scl_rise) begin
                            shift   <= wr_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= wr_byte;
                                ptr       <= ptr + 8'd1;
                                ack_drv   <= 1'b0;
                                state     <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                rd_ack <= 1'b0;
                                state  <= S_RDATA_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shift   <= {shift[6:0], 1'b0};
                                sda_oe  <= ~shift[6];
                            end
                        end
                    end
                    // The pointer only advances once the master ACKs a byte
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ptr    <= ptr + 8'd1;
                                rd_ack <= 1'b1;
                            end else begin
                                state <= S_WAIT_STOP;
                            end
                        end else if (scl_fall && rd_ack) begin
                            rd_ack  <= 1'b0;
                            shift   <= rd_byte;
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= 3'd0;
                            state   <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // I2C writes take priority over a simultaneous host write
    always_ff @(posedge clk) begin
        if (i2c_wr) begin
            mem[ptr] <= wr_byte;
        end else if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host_rdata   <= 8'd0;
            host_wr_drop <= 1'b0;
        end else begin
            host_rdata   <= mem[host_addr];
            host_wr_drop <= host_we && i2c_wr;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master driving i2c_slave_regfile; I2C register writes are
// checked by a scoreboard queue popped whenever wr_strobe pulses.
module tb_i2c_slave_regfile;

    localparam int Q = 10;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       host_wr_drop;
    logic       busy;

    int          tests = 0;
    int          fails = 0;
    int          drops = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_e;

    always #5 clk = ~clk;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_regfile #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .scl_i(scl_i),
        .sda_i(sda_i),
        .sda_oe(sda_oe),
        .host_addr(host_addr),
        .host_we(host_we),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .host_wr_drop(host_wr_drop),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for I2C register writes, plus drop pulse counting
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_strobe_unexpected: got addr 0x%0h data 0x%0h, expected none",
                         wr_addr, wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_strobe_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, exp_e});
            end
        end
        if (host_wr_drop) drops++;
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; nclk(Q);
        scl_m = 1'b1; nclk(Q);
        sda_m = 1'b0; nclk(Q);
        scl_m = 1'b0; nclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; nclk(Q);
        scl_m = 1'b1; nclk(Q);
        sda_m = 1'b1; nclk(Q);
    endtask

    // coll: pulse host_we in the clk the DUT acts on this rising edge
    task automatic send_bit(input logic b, input bit coll);
        sda_m = b; nclk(Q);
        scl_m = 1'b1;
        if (coll) begin
            nclk(2); host_we = 1'b1;
            nclk(1); host_we = 1'b0;
            nclk(H - 3);
        end else begin
            nclk(H);
        end
        scl_m = 1'b0; nclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit coll_last, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], coll_last && (i == 0));
        sda_m = 1'b1; nclk(Q);
        scl_m = 1'b1; nclk(H / 2);
        ack = sda_i;  nclk(H / 2);
        scl_m = 1'b0; nclk(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            nclk(Q);
            scl_m = 1'b1; nclk(H / 2);
            d[i] = sda_i; nclk(H / 2);
            scl_m = 1'b0; nclk(Q);
        end
        send_bit(nack, 1'b0);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        host_addr = a;
        nclk(2);
        d = host_rdata;
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         drops_before;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
        nclk(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_host_wr_drop", host_wr_drop, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        nclk(5);

        // Single byte write 0x10 -> reg 0x20
        exp_q.push_back({8'h20, 8'h10});
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("t1_addr_ack", ack, 0);
        check("t1_busy_high", busy, 1);
        write_byte(8'h20, 1'b0, ack); check("t1_ptr_ack", ack, 0);
        write_byte(8'h10, 1'b0, ack); check("t1_data_ack", ack, 0);
        i2c_stop();
        nclk(5);
        check("t1_busy_low", busy, 0);
        host_read(8'h20, d); check("t1_host_rdata", d, 8'h10);

        // Read with pointer wrap 0xFE -> 0xFF -> 0x00
        host_write(8'hFE, 8'hAA);
        host_write(8'hFF, 8'hBB);
        host_write(8'h00, 8'hCC);
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("t2_addr_w_ack", ack, 0);
        write_byte(8'hFE, 1'b0, ack); check("t2_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("t2_addr_r_ack", ack, 0);
        read_byte(1'b0, d); check("t2_rd0", d, 8'hAA);
        read_byte(1'b0, d); check("t2_rd1", d, 8'hBB);
        read_byte(1'b1, d); check("t2_rd2_wrap", d, 8'hCC);
        check("t2_busy_before_stop", busy, 1);
        i2c_stop();
        nclk(5);
        check("t2_busy_after_stop", busy, 0);
        // NACKed byte must not advance the pointer: next read starts at 0x00
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("t2b_addr_r_ack", ack, 0);
        read_byte(1'b1, d); check("t2b_ptr_held", d, 8'hCC);
        i2c_stop();

        // Wrong address 0x51: no ACK, no writes, busy stays low
        i2c_start();
        write_byte(8'hA2, 1'b0, ack); check("t3_addr_nack", ack, 1);
        check("t3_busy", busy, 0);
        write_byte(8'h30, 1'b0, ack); check("t3_byte1_nack", ack, 1);
        write_byte(8'h40, 1'b0, ack); check("t3_byte2_nack", ack, 1);
        i2c_stop();
        nclk(5);
        check("t3_busy_after", busy, 0);

        // Repeated START after 4 data bits discards the partial byte
        host_write(8'h40, 8'h11);
        exp_q.push_back({8'h41, 8'h55});
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("t4_addr_ack", ack, 0);
        write_byte(8'h40, 1'b0, ack); check("t4_ptr_ack", ack, 0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("t4_readdr_ack", ack, 0);
        write_byte(8'h41, 1'b0, ack); check("t4_ptr2_ack", ack, 0);
        write_byte(8'h55, 1'b0, ack); check("t4_data_ack", ack, 0);
        i2c_stop();
        host_read(8'h40, d); check("t4_partial_discarded", d, 8'h11);
        host_read(8'h41, d); check("t4_new_write", d, 8'h55);

        // Host write collides with I2C write to 0x05
        drops_before = drops;
        @(negedge clk);
        host_addr = 8'h05; host_wdata = 8'h33;
        exp_q.push_back({8'h05, 8'h77});
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("t5_addr_ack", ack, 0);
        write_byte(8'h05, 1'b0, ack); check("t5_ptr_ack", ack, 0);
        write_byte(8'h77, 1'b1, ack); check("t5_data_ack", ack, 0);
        i2c_stop();
        nclk(5);
        check("t5_drop_pulses", drops - drops_before, 1);
        host_read(8'h05, d); check("t5_i2c_wins", d, 8'h77);

        // Reset during RDATA while driving a zero bit
        host_write(8'h60, 8'h00);
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("t6_addr_w_ack", ack, 0);
        write_byte(8'h60, 1'b0, ack); check("t6_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'hA1, 1'b0, ack); check("t6_addr_r_ack", ack, 0);
        check("t6_sda_oe_driving", sda_oe, 1);
        rst = 1'b1;
        nclk(1);
        check("t6_rst_sda_oe", sda_oe, 0);
        check("t6_rst_busy", busy, 0);
        rst = 1'b0;
        i2c_stop();
        nclk(5);
        exp_q.push_back({8'h61, 8'h88});
        i2c_start();
        write_byte(8'hA0, 1'b0, ack); check("t6_post_addr_ack", ack, 0);
        write_byte(8'h61, 1'b0, ack); check("t6_post_ptr_ack", ack, 0);
        write_byte(8'h88, 1'b0, ack); check("t6_post_data_ack", ack, 0);
        i2c_stop();
        host_read(8'h61, d); check("t6_post_rdata", d, 8'h88);

        nclk(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
